// File: rtl/decode_pipe_stage_if.sv
`default_nettype none
// ============================================================================
// decode_pipe_stage_if : ID/EX bundle channel, valid/ready handshake.
// Rev 1.0
// ============================================================================
interface decode_pipe_stage_if #(
  parameter int DATA_W = 32
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] val_rn;
  logic [DATA_W-1:0] val_rm;
  logic              mem_r_en;
  logic              mem_w_en;
  logic              wb_en;
  logic              status_w_en;
  logic              branch_taken;
  logic              imm;
  logic [3:0]        exec_cmd;
  logic [11:0]       shift_operand;
  logic [23:0]       signed_imm_24;
  logic [3:0]        dest;
  logic [3:0]        src1;
  logic [3:0]        src2;

  modport master (
    output valid, pc, val_rn, val_rm, mem_r_en, mem_w_en, wb_en, status_w_en,
           branch_taken, imm, exec_cmd, shift_operand, signed_imm_24, dest, src1, src2,
    input  ready
  );

  modport slave (
    input  valid, pc, val_rn, val_rm, mem_r_en, mem_w_en, wb_en, status_w_en,
           branch_taken, imm, exec_cmd, shift_operand, signed_imm_24, dest, src1, src2,
    output ready
  );
endinterface
`default_nettype wire

// File: rtl/decode_pipe_stage.sv
`default_nettype none
// ============================================================================
// decode_pipe_stage : ARM-subset decode, register file, RAW hazard, ID/EX reg.
// DECODE_FORWARDING_EN restricts hazards to load-use.  Rev 1.0
// ============================================================================
module decode_pipe_stage #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [31:0]         instr_i,
  input  logic [DATA_W-1:0]   pc_in_i,
  input  logic [3:0]          status_i,
  input  logic                flush_i,
  input  logic                wb_en_in_i,
  input  logic [3:0]          wb_dest_i,
  input  logic [DATA_W-1:0]   wb_data_i,
  input  logic                mem_wb_en_i,
  input  logic [3:0]          mem_dest_i,
  output logic                hazard_o,
  decode_pipe_stage_if.master ex_if
);
  localparam logic [4:0] C_NREGS = 5'(NUM_REGS);

  logic [3:0]        w_cond, w_opcode, w_rn, w_rd, w_rm, w_src2;
  logic [1:0]        w_mode;
  logic              w_i, w_s, w_cond_ok, w_is_str, w_use_rn, w_use_src2;
  logic              w_dep_rn, w_dep_src2, w_advance;
  logic [8:0]        ctl_d;  // {mem_r, mem_w, wb, status_w, branch, exec_cmd[3:0]}
  logic [DATA_W-1:0] rn_val_d, rm_val_d;

  logic [DATA_W-1:0] rf_q [NUM_REGS];
  logic              valid_q;
  logic [8:0]        ctl_q;
  logic [DATA_W-1:0] pc_q, val_rn_q, val_rm_q;
  logic              imm_q;
  logic [11:0]       shift_q;
  logic [23:0]       simm_q;
  logic [3:0]        dest_q, src1_q, src2_q;

  assign w_cond   = instr_i[31:28];
  assign w_mode   = instr_i[27:26];
  assign w_i      = instr_i[25];
  assign w_opcode = instr_i[24:21];
  assign w_s      = instr_i[20];
  assign w_rn     = instr_i[19:16];
  assign w_rd     = instr_i[15:12];
  assign w_rm     = instr_i[3:0];
  assign w_is_str = (w_mode == 2'b01) && !w_s;
  assign w_src2   = w_is_str ? w_rd : w_rm;

  // status_i = {N, Z, C, V}
  always_comb begin
    case (w_cond)
      4'h0:    w_cond_ok = status_i[2];
      4'h1:    w_cond_ok = !status_i[2];
      4'h2:    w_cond_ok = status_i[1];
      4'h3:    w_cond_ok = !status_i[1];
      4'h4:    w_cond_ok = status_i[3];
      4'h5:    w_cond_ok = !status_i[3];
      4'h6:    w_cond_ok = status_i[0];
      4'h7:    w_cond_ok = !status_i[0];
      4'h8:    w_cond_ok = status_i[1] && !status_i[2];
      4'h9:    w_cond_ok = !status_i[1] || status_i[2];
      4'hA:    w_cond_ok = status_i[3] == status_i[0];
      4'hB:    w_cond_ok = status_i[3] != status_i[0];
      4'hC:    w_cond_ok = !status_i[2] && (status_i[3] == status_i[0]);
      4'hD:    w_cond_ok = status_i[2] || (status_i[3] != status_i[0]);
      4'hE:    w_cond_ok = 1'b1;
      default: w_cond_ok = 1'b0;
    endcase
  end

  always_comb begin
    ctl_d = '0;
    case (w_mode)
      2'b00: begin
        ctl_d[6:5] = {1'b1, w_s};
        case (w_opcode)
          4'b1101: ctl_d[3:0] = 4'b0001;
          4'b1111: ctl_d[3:0] = 4'b1001;
          4'b0100: ctl_d[3:0] = 4'b0010;
          4'b0101: ctl_d[3:0] = 4'b0011;
          4'b0010: ctl_d[3:0] = 4'b0100;
          4'b0110: ctl_d[3:0] = 4'b0101;
          4'b0000: ctl_d[3:0] = 4'b0110;
          4'b1100: ctl_d[3:0] = 4'b0111;
          4'b0001: ctl_d[3:0] = 4'b1000;
          4'b1010: begin ctl_d[3:0] = 4'b0100; ctl_d[6] = 1'b0; end
          4'b1000: begin ctl_d[3:0] = 4'b0110; ctl_d[6] = 1'b0; end
          default: ctl_d = '0;
        endcase
      end
      2'b01:   ctl_d = {w_s, !w_s, w_s, 2'b00, 4'b0010};
      2'b10:   ctl_d[4] = 1'b1;
      default: ctl_d = '0;
    endcase
    if (!w_cond_ok) ctl_d = '0;
  end

  // Out-of-range indices read zero even when the write port targets them.
  always_comb begin
    rn_val_d = '0;
    rm_val_d = '0;
    if ({1'b0, w_rn} < C_NREGS)
      rn_val_d = (wb_en_in_i && wb_dest_i == w_rn) ? wb_data_i : rf_q[w_rn];
    if ({1'b0, w_src2} < C_NREGS)
      rm_val_d = (wb_en_in_i && wb_dest_i == w_src2) ? wb_data_i : rf_q[w_src2];
  end

  assign w_use_rn   = !((w_mode == 2'b10) ||
                        ((w_mode == 2'b00) && (w_opcode == 4'b1101 || w_opcode == 4'b1111)));
  assign w_use_src2 = ((w_mode == 2'b00) && !w_i) || w_is_str;

`ifdef DECODE_FORWARDING_EN
  logic w_unused_mem;
  assign w_unused_mem = ^{mem_wb_en_i, mem_dest_i};
  assign w_dep_rn     = valid_q && ctl_q[8] && (w_rn == dest_q);
  assign w_dep_src2   = valid_q && ctl_q[8] && (w_src2 == dest_q);
`else
  assign w_dep_rn   = (valid_q && ctl_q[6] && (w_rn == dest_q)) ||
                      (mem_wb_en_i && (w_rn == mem_dest_i));
  assign w_dep_src2 = (valid_q && ctl_q[6] && (w_src2 == dest_q)) ||
                      (mem_wb_en_i && (w_src2 == mem_dest_i));
`endif

  assign hazard_o   = in_valid_i && w_cond_ok &&
                      ((w_use_rn && w_dep_rn) || (w_use_src2 && w_dep_src2));
  assign w_advance  = ex_if.ready || !valid_q;
  assign in_ready_o = w_advance && !hazard_o && !flush_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_REGS; k++) rf_q[k] <= '0;
    end else if (wb_en_in_i && ({1'b0, wb_dest_i} < C_NREGS)) begin
      rf_q[wb_dest_i] <= wb_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      ctl_q    <= '0;
      pc_q     <= '0;
      val_rn_q <= '0;
      val_rm_q <= '0;
      imm_q    <= 1'b0;
      shift_q  <= '0;
      simm_q   <= '0;
      dest_q   <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
      ctl_q   <= '0;
    end else if (w_advance && in_valid_i && !hazard_o) begin
      valid_q  <= 1'b1;
      ctl_q    <= ctl_d;
      pc_q     <= pc_in_i;
      val_rn_q <= rn_val_d;
      val_rm_q <= rm_val_d;
      imm_q    <= w_i;
      shift_q  <= instr_i[11:0];
      simm_q   <= instr_i[23:0];
      dest_q   <= w_rd;
      src1_q   <= w_rn;
      src2_q   <= w_src2;
    end else if (w_advance) begin
      valid_q <= 1'b0;
      ctl_q   <= '0;
    end
  end

  assign ex_if.valid = valid_q;
  assign {ex_if.mem_r_en, ex_if.mem_w_en, ex_if.wb_en, ex_if.status_w_en,
          ex_if.branch_taken, ex_if.exec_cmd} = ctl_q;
  assign ex_if.pc            = pc_q;
  assign ex_if.val_rn        = val_rn_q;
  assign ex_if.val_rm        = val_rm_q;
  assign ex_if.imm           = imm_q;
  assign ex_if.shift_operand = shift_q;
  assign ex_if.signed_imm_24 = simm_q;
  assign ex_if.dest          = dest_q;
  assign ex_if.src1          = src1_q;
  assign ex_if.src2          = src2_q;
endmodule
`default_nettype wire

// File: doc/decode_pipe_stage.md
# decode_pipe_stage

Parametrised instruction-decode stage with an integrated register file, condition check, RAW hazard detection and a registered ID/EX pipeline boundary with valid/ready flow control. It sits between the fetch stage and the execute stage. It decodes the 32-bit ARM-subset instruction, reads operands, and gates control on the NZCV condition. It either advances a decoded bundle, inserts a bubble on a hazard, or flushes on a taken branch.

## Interface
- DATA_W, 32, datapath width of PC, register contents and operands (≥32)
- NUM_REGS, 15, architectural registers R0..R(NUM_REGS-1); index width fixed at 4
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  fetch offers instr/pc_in
- in_ready  out  1  stage accepts this cycle (combinational)
- instr  in  32  instruction word
- pc_in  in  DATA_W  PC+4 of instr
- status  in  4  NZCV from status register
- flush  in  1  taken branch in EX; kill ID/EX contents and current input
- out_ready  in  1  execute can accept
- wb_en_in / wb_dest / wb_data  in  1/4/DATA_W  register-file write port
- mem_wb_en / mem_dest  in  1/4  MEM-stage writer, for hazard check
- hazard  out  1  RAW stall request to fetch (combinational)
- out_valid  out  1  ID/EX bundle valid
- pc_out, val_rn, val_rm  out  DATA_W  registered
- mem_r_en, mem_w_en, wb_en, status_w_en, branch_taken, imm  out  1 each  registered
- exec_cmd  out  4; shift_operand  out  12; signed_imm_24  out  24; dest, src1, src2  out  4 each

## Operation
- Fields: cond[31:28], mode[27:26], I[25], opcode[24:21], S[20], rn[19:16], rd[15:12], rm[3:0].
- Decode for mode 00 (opcode→exec_cmd, wb_en=1 unless noted): MOV 1101→0001, MVN 1111→1001, ADD 0100→0010, ADC 0101→0011, SUB 0010→0100, SBC 0110→0101, AND 0000→0110, ORR 1100→0111, EOR 0001→1000, CMP 1010→0100 (wb_en=0), TST 1000→0110 (wb_en=0). status_w_en=S. Undefined opcode → all control 0.
- Mode 01: exec_cmd=0010; S=1 LDR (mem_r_en, wb_en), S=0 STR (mem_w_en). Mode 10: branch_taken=1, exec_cmd=0000. Mode 11: all control 0.
- imm=I. src1=rn. src2=rd for STR, else rm.
- Condition: EQ..LE per ARM on status; 1110 AL true; 1111 false. Failed condition: bundle still issues (out_valid=1, pc/operands loaded) with all control bits 0.
- Register file: NUM_REGS×DATA_W. Write at posedge when wb_en_in and wb_dest<NUM_REGS. Reads are combinational with write bypass: a read address equal to wb_dest with wb_en_in returns wb_data. An index ≥NUM_REGS reads 0.
- Uses: rn used unless branch or MOV/MVN. src2 used when (mode 00 and I=0) or STR.
- Hazard, only for in_valid and an instruction whose condition passes, for each used source s:
  - (out_valid & wb_en & s==dest) or (mem_wb_en & s==mem_dest).
- advance = out_ready | ~out_valid. in_ready = advance & ~hazard & ~flush.
- Register update, by priority:
  1. flush: out_valid←0, all control←0.
  2. advance & in_valid & ~hazard: load bundle, out_valid←1.
  3. advance otherwise: bubble, out_valid←0, control←0.
  4. Else hold.

## Timing
- Reset: all outputs and register-file entries 0; out_valid=0. With out_valid=0 and no flush, in_ready=1.
- Latency 1 cycle from accepted input to out_valid.
- Zero-bubble throughput when no hazard. Each hazard inserts bubbles until the producer leaves EX/MEM.
- A write-back in the same cycle as a read is visible in that read.
- Write-back proceeds during flush, stall and hazard.
- Reset asserted mid-stream clears everything immediately; the first accept can occur in the first cycle after release.
- Stall (out_ready=0, out_valid=1) holds every output bit-stable.

## Configuration
- DECODE_FORWARDING_EN defined: the EX forwarding unit serves RAW hazards. hazard asserts only for a load-use case: out_valid & mem_r_en & s==dest. The MEM comparison is ignored.
- Undefined: full hazard rule above.

## Test plan
- Reset, then ADD R1,R2,R3 (0xE0821003) with out_ready=1 → next cycle out_valid=1, exec_cmd=0010, wb_en=1, dest=1, src1=2, src2=3.
- Write R2=0x5 via the WB port in the same cycle as decoding ADD using R2 → val_rn=0x5.
- ADD R1,… followed by SUB R4,R1,R5 → hazard=1 and in_ready=0 for one cycle, then a bubble (out_valid=0). Without the macro, stall persists while mem_dest=1; with the macro, no stall.
- Status=0000 with BEQ (0x0A000010) → out_valid=1, branch_taken=0, all control 0. Status Z=1 → branch_taken=1, signed_imm_24=0x000010.
- out_ready=0 for 3 cycles with a valid bundle → outputs held and in_ready=0. Then assert flush together with in_valid → out_valid=0 next cycle and the input is not consumed.
- Assert rst mid-stall → out_valid and all control 0 asynchronously; previously written R7 reads 0.
